// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch serial blocks: ASCII constants used in
// reports, the report length, field limits, the reporter FSM state type, a
// time-snapshot struct and a two-digit ASCII conversion helper.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  // Report framing characters
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // "HH:MM:SS.CC" + CR + LF
  localparam int MSG_LEN = 13;

  // Largest legal value of each time field
  localparam logic [6:0] CSEC_MAX = 7'd99;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    IDLE,  // waiting for a trigger
    LOAD,  // select the next byte and start its frame
    SEND,  // frame in flight
    DONE   // message complete, one-cycle completion pulse
  } state_t;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] csec;
  } time_t;

  // Two ASCII digits {tens, ones} for a value already limited to 0..99.
  function automatic logic [15:0] to_ascii2(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {ASCII_ZERO + {1'b0, tens}, ASCII_ZERO + {1'b0, ones}};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter. A start strobe while idle captures a byte and sends
// start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
// done is high during the final clock of the stop bit, so a caller that
// restarts on done inserts exactly one idle clock between frames.
//   clk    - system clock
//   reset  - asynchronous active-low reset (line forced idle high)
//   data   - byte to send, sampled with start
//   start  - start strobe, ignored while a frame is in flight
//   tx     - serial line, idle high
//   done   - last clock of the stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       done
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;       // clocks spent in the current bit
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [9:0]       frame;     // bit 0 is the bit currently on the line

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '1;
    end else if (!active) begin
      if (start) begin
        frame   <= {1'b1, data, 1'b0};
        tx      <= 1'b0;
        active  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        frame   <= {1'b1, frame[9:1]};
        tx      <= frame[1];
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = active && (bit_idx == 4'd9) && (cnt == CNT_LAST);

endmodule

// File: rtl/time_uart_reporter.sv
// -----------------------------------------------------------------------------
// time_uart_reporter
// Sends the current stopwatch time as the 13-byte ASCII report
// "HH:MM:SS.CC\r\n" over an 8N1 UART, on request or automatically on every
// change of the seconds field.
//   clk          - system clock
//   reset        - asynchronous active-low reset, aborts any message
//   i_msec       - centiseconds 0..99 (larger values saturate to 99)
//   i_sec, i_min - seconds / minutes 0..59 (saturate to 59)
//   i_hour       - hours 0..23 (saturate to 23)
//   i_req        - one-cycle send request; one request is queued while busy
//   i_auto       - level; report on each change of i_sec (dropped while busy)
//   o_tx         - UART serial line, idle high
//   o_busy       - message in progress
//   o_done       - one-cycle pulse at message completion
// -----------------------------------------------------------------------------
module time_uart_reporter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_req,
  input  logic       i_auto,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [3:0] LAST_IDX     = 4'(MSG_LEN - 1);

  state_t     state;
  time_t      snap;
  time_t      live;
  logic [3:0] byte_idx;
  logic       pending;
  logic [5:0] prev_sec;
  logic       prev_valid;   // blocks a spurious auto trigger right after reset
  logic       auto_trig;
  logic       trigger;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] tx_byte;
  logic [15:0] hh, mm, ss, cc;

  // Saturate the live inputs so the snapshot always holds printable values
  assign live.csec = (i_msec > CSEC_MAX) ? CSEC_MAX : i_msec;
  assign live.sec  = (i_sec  > SEC_MAX)  ? SEC_MAX  : i_sec;
  assign live.min  = (i_min  > MIN_MAX)  ? MIN_MAX  : i_min;
  assign live.hour = (i_hour > HOUR_MAX) ? HOUR_MAX : i_hour;

  assign auto_trig = i_auto && prev_valid && (i_sec != prev_sec);
  assign trigger   = i_req || auto_trig;
  assign tx_start  = (state == LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sec   <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_sec   <= i_sec;
      prev_valid <= 1'b1;
    end
  end

  assign hh = to_ascii2({2'b00, snap.hour});
  assign mm = to_ascii2({1'b0, snap.min});
  assign ss = to_ascii2({1'b0, snap.sec});
  assign cc = to_ascii2(snap.csec);

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it unlisted indices would infer a latch.
  always_comb begin
    tx_byte = ASCII_LF;
    case (byte_idx)
      4'd0:    tx_byte = hh[15:8];
      4'd1:    tx_byte = hh[7:0];
      4'd2:    tx_byte = ASCII_COLON;
      4'd3:    tx_byte = mm[15:8];
      4'd4:    tx_byte = mm[7:0];
      4'd5:    tx_byte = ASCII_COLON;
      4'd6:    tx_byte = ss[15:8];
      4'd7:    tx_byte = ss[7:0];
      4'd8:    tx_byte = ASCII_DOT;
      4'd9:    tx_byte = cc[15:8];
      4'd10:   tx_byte = cc[7:0];
      4'd11:   tx_byte = ASCII_CR;
      default: tx_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snap     <= '0;
      byte_idx <= '0;
      pending  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap     <= live;
            byte_idx <= '0;
            o_busy   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (i_req) pending <= 1'b1;
          state <= SEND;
        end
        SEND: begin
          if (i_req) pending <= 1'b1;
          if (tx_done) begin
            if (byte_idx == LAST_IDX) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= LOAD;
            end
          end
        end
        DONE: begin
          // A queued request restarts immediately with a fresh snapshot;
          // auto triggers seen during the message are not remembered.
          if (pending || i_req) begin
            snap     <= live;
            byte_idx <= '0;
            pending  <= 1'b0;
            o_busy   <= 1'b1;
            state    <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .data  (tx_byte),
    .start (tx_start),
    .tx    (o_tx),
    .done  (tx_done)
  );

endmodule
